ks_pipe_adder: RTL and testbench

Parametrised, pipelined Kogge-Stone adder/subtractor with valid/ready flow control. It generalises the fixed 32-bit combinational prefix levels to any power-of-two width. It inserts pipeline registers every REG_EVERY prefix levels and adds per-transaction subtract mode, signed-overflow detection and backpressure. It is the arithmetic core that streaming datapaths instantiate in place of the flat adder.

---
 rtl/ks_pipe_adder.sv | 140 ++++++++++++++
 tb/tb_ks_pipe_adder.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ks_pipe_adder.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready flow control.
// Pipeline registers follow every REG_EVERY prefix levels; the last one holds the result.
module ks_pipe_adder #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned REG_EVERY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned LEVELS = $clog2(WIDTH);
  localparam int unsigned NREG   = (LEVELS + REG_EVERY - 1) / REG_EVERY;

  // Stage 0 next-state
  logic [WIDTH-1:0] bb_d, p0_d, g0_d;
  logic             c0_d;

  always_comb begin
    bb_d    = sub ? ~b : b;
    c0_d    = sub | cin;
    p0_d    = a ^ bb_d;
    g0_d    = a & bb_d;
    g0_d[0] = g0_d[0] | (p0_d[0] & c0_d);
  end

  // Stages 0..NREG-1 carry prefix state; stage NREG is the output stage
  logic [WIDTH-1:0] op_q [NREG];
  logic [WIDTH-1:0] gp_q [NREG];
  logic [WIDTH-1:0] pp_q [NREG];
  logic             c0_q [NREG];
  logic             am_q [NREG];
  logic             bm_q [NREG];
  logic [NREG:0]    vld_q;
  logic [NREG:0]    rdy;
  logic             all_v;

  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] lv_gi [1:LEVELS];
  logic [WIDTH-1:0] lv_pi [1:LEVELS];
  logic [WIDTH-1:0] lv_go [1:LEVELS];
  logic [WIDTH-1:0] lv_po [1:LEVELS];

  for (genvar k = 1; k <= LEVELS; k++) begin : g_level
    localparam int unsigned D = 1 << (k - 1);
    localparam logic [WIDTH-1:0] LOW = ~({WIDTH{1'b1}} << D);

    if (((k - 1) % REG_EVERY) == 0) begin : g_from_reg
      assign lv_gi[k] = gp_q[(k - 1) / REG_EVERY];
      assign lv_pi[k] = pp_q[(k - 1) / REG_EVERY];
    end else begin : g_from_comb
      assign lv_gi[k] = lv_go[k - 1];
      assign lv_pi[k] = lv_po[k - 1];
    end

    // Shifted-in zeros make bits below D pass through unchanged
    assign lv_go[k] = lv_gi[k] | (lv_pi[k] & (lv_gi[k] << D));
    assign lv_po[k] = lv_pi[k] & ((lv_pi[k] << D) | LOW);
  end

  always_comb begin
    sum_d  = op_q[NREG-1] ^ {lv_go[LEVELS][WIDTH-2:0], c0_q[NREG-1]};
    cout_d = lv_go[LEVELS][WIDTH-1];
    ovf_d  = (am_q[NREG-1] == bm_q[NREG-1]) & (sum_d[WIDTH-1] != am_q[NREG-1]);
  end

  // A stage is ready unless it and every stage after it is full while out_ready is low
  always_comb begin
    rdy   = '0;
    all_v = 1'b1;
    for (int unsigned j = 0; j <= NREG; j++) begin
      all_v         = all_v & vld_q[NREG - j];
      rdy[NREG - j] = out_ready | ~all_v;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int unsigned s = 0; s < NREG; s++) begin
        op_q[s] <= '0;
        gp_q[s] <= '0;
        pp_q[s] <= '0;
        c0_q[s] <= 1'b0;
        am_q[s] <= 1'b0;
        bm_q[s] <= 1'b0;
      end
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (rdy[0]) begin
        vld_q[0] <= in_valid;
        op_q[0]  <= p0_d;
        gp_q[0]  <= g0_d;
        pp_q[0]  <= p0_d;
        c0_q[0]  <= c0_d;
        am_q[0]  <= a[WIDTH-1];
        bm_q[0]  <= bb_d[WIDTH-1];
      end
      for (int unsigned s = 1; s < NREG; s++) begin
        if (rdy[s]) begin
          vld_q[s] <= vld_q[s-1];
          op_q[s]  <= op_q[s-1];
          gp_q[s]  <= lv_go[s * REG_EVERY];
          pp_q[s]  <= lv_po[s * REG_EVERY];
          c0_q[s]  <= c0_q[s-1];
          am_q[s]  <= am_q[s-1];
          bm_q[s]  <= bm_q[s-1];
        end
      end
      if (rdy[NREG]) begin
        vld_q[NREG] <= vld_q[NREG-1];
        sum_q       <= sum_d;
        cout_q      <= cout_d;
        ovf_q       <= ovf_d;
      end
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = vld_q[NREG];
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_ks_pipe_adder.sv
// Scoreboard bench for ks_pipe_adder: a 32-bit/REG_EVERY=1 instance and an 8-bit/REG_EVERY=2 instance.
module tb_ks_pipe_adder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        x_in_valid, x_in_ready, x_cin, x_sub, x_out_valid, x_out_ready, x_cout, x_ovf;
  logic [31:0] x_a, x_b, x_sum;
  logic        y_in_valid, y_in_ready, y_cin, y_sub, y_out_valid, y_out_ready, y_cout, y_ovf;
  logic [7:0]  y_a, y_b, y_sum;

  ks_pipe_adder #(.WIDTH(32), .REG_EVERY(1)) u_x (
    .clk(clk), .rst_n(rst_n), .in_valid(x_in_valid), .in_ready(x_in_ready),
    .a(x_a), .b(x_b), .cin(x_cin), .sub(x_sub),
    .out_valid(x_out_valid), .out_ready(x_out_ready),
    .sum(x_sum), .cout(x_cout), .ovf(x_ovf)
  );

  ks_pipe_adder #(.WIDTH(8), .REG_EVERY(2)) u_y (
    .clk(clk), .rst_n(rst_n), .in_valid(y_in_valid), .in_ready(y_in_ready),
    .a(y_a), .b(y_b), .cin(y_cin), .sub(y_sub),
    .out_valid(y_out_valid), .out_ready(y_out_ready),
    .sum(y_sum), .cout(y_cout), .ovf(y_ovf)
  );

  typedef struct {
    logic [65:0] exp;
    int unsigned cyc;
    bit          lat;
  } sb_t;

  sb_t         qx[$];
  sb_t         qy[$];
  sb_t         ex, ey;
  int unsigned ntests = 0;
  int unsigned nfail  = 0;
  int unsigned cyc    = 0;
  int unsigned cnt;
  bit          acc;
  bit          x_lat, x_rnd, y_lat, y_rnd;
  bit          x_hold, y_hold;
  logic [33:0] x_prev;
  logic [9:0]  y_prev;

  always @(posedge clk) cyc++;

  function automatic logic [65:0] ref_add(input int unsigned n, input logic [63:0] av,
                                          input logic [63:0] bv, input logic c, input logic s);
    logic [63:0] m, bb, r;
    logic [64:0] full;
    m = '1;
    if (n < 64) m = (64'd1 << n) - 64'd1;
    bb   = (s ? ~bv : bv) & m;
    full = {1'b0, av & m} + {1'b0, bb} + {64'd0, (s | c)};
    r    = full[63:0] & m;
    return {(av[n-1] == bb[n-1]) && (r[n-1] != av[n-1]), full[n], r};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors sample at the falling edge what the next rising edge will transfer
  always @(negedge clk) begin
    if (!rst_n) begin
      x_hold = 1'b0;
    end else begin
      if (x_hold && x_out_valid) chk("x_hold_stable", {x_ovf, x_cout, x_sum}, x_prev);
      x_hold = x_out_valid && !x_out_ready;
      x_prev = {x_ovf, x_cout, x_sum};
      if (x_out_valid && x_out_ready) begin
        ntests++;
        assert (qx.size() != 0) else begin
          nfail++;
          $error("FAIL x_unexpected_output: observed sum=%0h expected no output", x_sum);
        end
        if (qx.size() != 0) begin
          ex = qx.pop_front();
          chk("x_result", {x_ovf, x_cout, 32'd0, x_sum}, ex.exp);
          if (ex.lat) chk("x_latency", cyc - ex.cyc, 6);
        end
      end
      if (x_in_valid && x_in_ready) begin
        ex.exp = ref_add(32, {32'd0, x_a}, {32'd0, x_b}, x_cin, x_sub);
        ex.cyc = cyc;
        ex.lat = x_lat;
        qx.push_back(ex);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      y_hold = 1'b0;
    end else begin
      if (y_hold && y_out_valid) chk("y_hold_stable", {y_ovf, y_cout, y_sum}, y_prev);
      y_hold = y_out_valid && !y_out_ready;
      y_prev = {y_ovf, y_cout, y_sum};
      if (y_out_valid && y_out_ready) begin
        ntests++;
        assert (qy.size() != 0) else begin
          nfail++;
          $error("FAIL y_unexpected_output: observed sum=%0h expected no output", y_sum);
        end
        if (qy.size() != 0) begin
          ey = qy.pop_front();
          chk("y_result", {y_ovf, y_cout, 56'd0, y_sum}, ey.exp);
          if (ey.lat) chk("y_latency", cyc - ey.cyc, 3);
        end
      end
      if (y_in_valid && y_in_ready) begin
        ey.exp = ref_add(8, {56'd0, y_a}, {56'd0, y_b}, y_cin, y_sub);
        ey.cyc = cyc;
        ey.lat = y_lat;
        qy.push_back(ey);
      end
    end
  end

  task automatic send_x(input logic [31:0] av, input logic [31:0] bv, input logic c, input logic s);
    bit ok;
    ok = 1'b0;
    x_a = av; x_b = bv; x_cin = c; x_sub = s; x_in_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = x_in_ready;
      tick();
      if (x_rnd) x_out_ready = 1'($urandom_range(0, 1));
    end
    ntests++;
    assert (ok) else begin
      nfail++;
      $error("FAIL x_send_timeout: observed accepted=%0d expected 1", ok);
    end
  endtask

  task automatic send_y(input logic [7:0] av, input logic [7:0] bv, input logic c, input logic s);
    bit ok;
    ok = 1'b0;
    y_a = av; y_b = bv; y_cin = c; y_sub = s; y_in_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = y_in_ready;
      tick();
      if (y_rnd) y_out_ready = 1'($urandom_range(0, 1));
    end
    ntests++;
    assert (ok) else begin
      nfail++;
      $error("FAIL y_send_timeout: observed accepted=%0d expected 1", ok);
    end
  endtask

  task automatic expect_x(input logic [31:0] es, input logic ec, input logic eo, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = x_out_valid;
    end
    chk({tag, "_valid"}, seen, 1);
    chk({tag, "_sum"}, x_sum, es);
    chk({tag, "_cout"}, x_cout, ec);
    chk({tag, "_ovf"}, x_ovf, eo);
    tick();
  endtask

  task automatic drain_x();
    for (int i = 0; i < 100 && qx.size() != 0; i++) tick();
    chk("x_drain_pending", qx.size(), 0);
  endtask

  task automatic drain_y();
    for (int i = 0; i < 100 && qy.size() != 0; i++) tick();
    chk("y_drain_pending", qy.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    x_in_valid = 1'b0; x_a = '0; x_b = '0; x_cin = 1'b0; x_sub = 1'b0; x_out_ready = 1'b1;
    y_in_valid = 1'b0; y_a = '0; y_b = '0; y_cin = 1'b0; y_sub = 1'b0; y_out_ready = 1'b1;
    x_lat = 1'b1; x_rnd = 1'b0; y_lat = 1'b1; y_rnd = 1'b0;

    #2;
    chk("rst_out_valid", x_out_valid, 0);
    chk("rst_sum", x_sum, 0);
    chk("rst_cout_ovf", {x_cout, x_ovf}, 0);
    chk("rst_in_ready", x_in_ready, 1);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("idle_after_reset", x_out_valid, 0);

    send_x(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    x_in_valid = 1'b0;
    expect_x(32'h0000_0000, 1'b1, 1'b0, "add_ripple");
    send_x(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    x_in_valid = 1'b0;
    expect_x(32'h8000_0000, 1'b0, 1'b1, "add_ovf");
    send_x(32'd5, 32'd7, 1'b0, 1'b1);
    x_in_valid = 1'b0;
    expect_x(32'hFFFF_FFFE, 1'b0, 1'b0, "sub_borrow");
    send_x(32'h8000_0000, 32'd1, 1'b0, 1'b1);
    x_in_valid = 1'b0;
    expect_x(32'h7FFF_FFFF, 1'b1, 1'b1, "sub_ovf");
    send_x(32'd5, 32'd7, 1'b1, 1'b1);
    x_in_valid = 1'b0;
    expect_x(32'hFFFF_FFFE, 1'b0, 1'b0, "sub_cin_ignored");
    send_x(32'h0000_00FF, 32'h0000_0000, 1'b1, 1'b0);
    x_in_valid = 1'b0;
    expect_x(32'h0000_0100, 1'b0, 1'b0, "add_cin");

    for (int i = 0; i < 1000; i++)
      send_x($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    x_in_valid = 1'b0;
    drain_x();

    // Backpressure: only the stages of the pipe can fill
    x_lat = 1'b0;
    x_out_ready = 1'b0;
    cnt = 0;
    x_a = $urandom; x_b = $urandom; x_cin = 1'b0; x_sub = 1'b0; x_in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      acc = x_in_ready;
      if (acc) cnt++;
      tick();
      if (acc) begin x_a = $urandom; x_b = $urandom; x_sub = 1'($urandom_range(0, 1)); end
    end
    chk("bp_accepted", cnt, 6);
    chk("bp_in_ready_low", x_in_ready, 0);
    x_in_valid = 1'b0;
    x_out_ready = 1'b1;
    drain_x();

    x_rnd = 1'b1;
    for (int i = 0; i < 300; i++)
      send_x($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    x_rnd = 1'b0;
    x_in_valid = 1'b0;
    x_out_ready = 1'b1;
    drain_x();

    // Asynchronous reset with a full, stalled pipe
    x_out_ready = 1'b0;
    send_x(32'h8000_0000, 32'h8000_0001, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send_x($urandom, $urandom, 1'b0, 1'b0);
    x_in_valid = 1'b0;
    chk("full_in_ready", x_in_ready, 0);
    chk("full_out_valid", x_out_valid, 1);
    chk("full_head", {x_ovf, x_cout, x_sum}, {2'b11, 32'h0000_0001});
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", x_out_valid, 0);
    chk("async_rst_sum", x_sum, 0);
    chk("async_rst_cout_ovf", {x_cout, x_ovf}, 0);
    chk("async_rst_in_ready", x_in_ready, 1);
    qx.delete();
    x_out_ready = 1'b1;
    tick();
    rst_n = 1'b1;

    // Reset while four transactions are in flight
    x_lat = 1'b1;
    for (int i = 0; i < 4; i++) send_x($urandom, $urandom, 1'b0, 1'b0);
    x_in_valid = 1'b0;
    rst_n = 1'b0;
    qx.delete();
    #5;
    rst_n = 1'b1;
    chk("midrst_out_valid", x_out_valid, 0);
    repeat (12) tick();
    chk("midrst_idle", x_out_valid, 0);
    send_x(32'd100, 32'd23, 1'b1, 1'b0);
    x_in_valid = 1'b0;
    expect_x(32'd124, 1'b0, 1'b0, "post_reset");
    drain_x();

    for (int i = 0; i < 300; i++)
      send_y(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    y_in_valid = 1'b0;
    drain_y();
    y_lat = 1'b0;
    y_rnd = 1'b1;
    for (int i = 0; i < 200; i++)
      send_y(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    y_rnd = 1'b0;
    y_in_valid = 1'b0;
    y_out_ready = 1'b1;
    drain_y();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
